// File: rtl/fft_pkg.sv
// Shared FFT definitions: default geometry, packer state encoding and the
// index bit-reversal helper used by every block that permutes sample order.
package fft_pkg;

   localparam int WIDTH_DEF  = 16;
   localparam int NPOINT_DEF = 3;
   localparam int N          = 1 << NPOINT_DEF;

   typedef enum logic {
      FILL = 1'b0,
      FULL = 1'b1
   } state_e;

   // Reverses the low nbits of idx; bits above nbits come back as zero.
   function automatic logic [31:0] bitrev(input logic [31:0] idx, input int nbits);
      logic [31:0] r;
      r = '0;
      for (int i = 0; i < nbits; i++)
         r[i] = idx[nbits-1-i];
      return r;
   endfunction

endpackage

// File: rtl/fft_bitrev_map.sv
// Sample-index to buffer-slot mapper: bit-reversed when BITREV, identity otherwise.
module fft_bitrev_map
   import fft_pkg::*;
#(
   parameter int NPOINT = NPOINT_DEF,
   parameter int BITREV = 1
) (
   input  logic [NPOINT-1:0] idx_i,
   output logic [NPOINT-1:0] slot_o
);

   assign slot_o = (BITREV != 0) ? NPOINT'(bitrev(32'(idx_i), NPOINT)) : idx_i;

endmodule

// File: rtl/fft_din_packer.sv
// Packs a stream of complex samples into N-sample frames for the parallel FFT
// input bus, optionally pre-permuted into bit-reversed order.
module fft_din_packer
   import fft_pkg::*;
#(
   parameter int WIDTH  = WIDTH_DEF,
   parameter int NPOINT = NPOINT_DEF,
   parameter int BITREV = 1
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         sin_valid,
   output logic                         sin_busy,
   input  logic                         sin_sof,
   input  logic [WIDTH-1:0]             sin_real,
   input  logic [WIDTH-1:0]             sin_imag,
   output logic                         dout_valid,
   input  logic                         dout_busy,
   output logic [WIDTH*(1<<NPOINT)-1:0] dout_real,
   output logic [WIDTH*(1<<NPOINT)-1:0] dout_imag,
   output logic                         frame_err
);

   localparam int NS = 1 << NPOINT;
   localparam logic [NPOINT-1:0] CNT_MAX = '1;

   typedef logic [NS-1:0][WIDTH-1:0] frame_t;

   state_e              state_q, state_d;
   logic [NPOINT-1:0]   cnt_q, cnt_d;
   frame_t              buf_re_q, buf_re_d, buf_im_q, buf_im_d;
   frame_t              out_re_q, out_re_d, out_im_q, out_im_d;
   logic                dv_q, dv_d;
   logic                err_q;

   logic                accept, out_free, restart, last_acc, load;
   logic [NPOINT-1:0]   idx, slot;

   assign sin_busy   = (state_q == FULL);
   assign accept     = sin_valid & ~sin_busy;
   assign out_free   = ~dv_q | ~dout_busy;
   // A start-of-frame mid-frame abandons the partial frame and restarts at slot map(0).
   assign restart    = accept & sin_sof & (cnt_q != '0);
   assign idx        = restart ? '0 : cnt_q;
   assign last_acc   = accept & ~restart & (cnt_q == CNT_MAX);

   fft_bitrev_map #(
      .NPOINT (NPOINT),
      .BITREV (BITREV)
   ) u_map (
      .idx_i  (idx),
      .slot_o (slot)
   );

   always_comb begin
      buf_re_d = buf_re_q;
      buf_im_d = buf_im_q;
      cnt_d    = cnt_q;
      state_d  = state_q;
      load     = 1'b0;
      if (accept) begin
         buf_re_d[slot] = sin_real;
         buf_im_d[slot] = sin_imag;
         cnt_d          = restart ? NPOINT'(1) : cnt_q + 1'b1;
      end
      case (state_q)
         FILL: if (last_acc) begin
            if (out_free) load = 1'b1;
            else          state_d = FULL;
         end
         FULL: if (out_free) begin
            load    = 1'b1;
            state_d = FILL;
         end
         default: state_d = FILL;
      endcase
      // buf_*_d already carries the final sample, so a completing accept
      // loads the whole frame in the same edge.
      out_re_d = load ? buf_re_d : out_re_q;
      out_im_d = load ? buf_im_d : out_im_q;
      dv_d     = load | (dv_q & dout_busy);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= FILL;
         cnt_q    <= '0;
         dv_q     <= 1'b0;
         out_re_q <= '0;
         out_im_q <= '0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         dv_q     <= dv_d;
         out_re_q <= out_re_d;
         out_im_q <= out_im_d;
         err_q    <= restart;
      end
   end

   always_ff @(posedge clk) begin
      buf_re_q <= buf_re_d;
      buf_im_q <= buf_im_d;
   end

   assign dout_valid = dv_q;
   assign dout_real  = out_re_q;
   assign dout_imag  = out_im_q;
   assign frame_err  = err_q;

endmodule

// File: tb/tb_fft_din_packer.sv
// Directed bench for fft_din_packer: a bit-reversing and a natural-order
// instance share one stimulus stream; a cycle model predicts handshakes and frames.
module tb_fft_din_packer;

   localparam int W  = 16;
   localparam int NP = 3;
   localparam int NN = 8;

   typedef logic [W*NN-1:0] frame_t;

   logic clk = 1'b0, rst = 1'b1;
   logic sin_valid = 1'b0, sin_sof = 1'b0, dout_busy = 1'b0;
   logic [W-1:0] sin_real = '0, sin_imag = '0;
   logic busy_a, busy_b, dv_a, dv_b, err_a, err_b;
   frame_t re_a, im_a, re_b, im_b;

   always #5 clk = ~clk;

   fft_din_packer #(.WIDTH(W), .NPOINT(NP), .BITREV(1)) dut_a (
      .clk(clk), .rst(rst), .sin_valid(sin_valid), .sin_busy(busy_a), .sin_sof(sin_sof),
      .sin_real(sin_real), .sin_imag(sin_imag), .dout_valid(dv_a), .dout_busy(dout_busy),
      .dout_real(re_a), .dout_imag(im_a), .frame_err(err_a));

   fft_din_packer #(.WIDTH(W), .NPOINT(NP), .BITREV(0)) dut_b (
      .clk(clk), .rst(rst), .sin_valid(sin_valid), .sin_busy(busy_b), .sin_sof(sin_sof),
      .sin_real(sin_real), .sin_imag(sin_imag), .dout_valid(dv_b), .dout_busy(dout_busy),
      .dout_real(re_b), .dout_imag(im_b), .frame_err(err_b));

   int n_vec = 0, n_bad = 0;
   frame_t qa_re[$], qa_im[$], qb_re[$], qb_im[$];
   logic [W-1:0] mre[NN], mim[NN];
   int m_cnt = 0;
   bit m_full = 0, m_dv = 0, m_err = 0;

   task automatic chk(input string tag, input frame_t obs, input frame_t exp);
      n_vec++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic int brev(input int k);
      int r = 0;
      for (int b = 0; b < NP; b++)
         if (k[b]) r |= 1 << (NP-1-b);
      return r;
   endfunction

   task automatic push_frame();
      frame_t far, fai, fbr, fbi;
      for (int k = 0; k < NN; k++) begin
         far[brev(k)*W +: W] = mre[k];
         fai[brev(k)*W +: W] = mim[k];
         fbr[k*W +: W]       = mre[k];
         fbi[k*W +: W]       = mim[k];
      end
      qa_re.push_back(far); qa_im.push_back(fai);
      qb_re.push_back(fbr); qb_im.push_back(fbi);
   endtask

   // One clock: check handshake outputs against the model, then advance it.
   task automatic cycle();
      bit acc, free, load;
      @(negedge clk);
      if (!rst) begin
         chk("sin_busy_a", frame_t'(busy_a), frame_t'(m_full));
         chk("sin_busy_b", frame_t'(busy_b), frame_t'(m_full));
         chk("dout_valid_a", frame_t'(dv_a), frame_t'(m_dv));
         chk("dout_valid_b", frame_t'(dv_b), frame_t'(m_dv));
         chk("frame_err_a", frame_t'(err_a), frame_t'(m_err));
         chk("frame_err_b", frame_t'(err_b), frame_t'(m_err));
      end
      if (rst) begin
         m_cnt = 0; m_full = 0; m_dv = 0; m_err = 0;
         qa_re.delete(); qa_im.delete(); qb_re.delete(); qb_im.delete();
      end else begin
         acc   = sin_valid && !m_full;
         free  = !m_dv || !dout_busy;
         load  = 0;
         m_err = 0;
         if (m_full && free) begin
            load = 1; m_full = 0;
         end else if (acc) begin
            if (sin_sof && m_cnt != 0) begin m_cnt = 0; m_err = 1; end
            mre[m_cnt] = sin_real;
            mim[m_cnt] = sin_imag;
            if (m_cnt == NN-1) begin
               push_frame();
               m_cnt = 0;
               if (free) load = 1; else m_full = 1;
            end else m_cnt++;
         end
         m_dv = load || (m_dv && dout_busy);
      end
      @(posedge clk); #1;
   endtask

   task automatic drive(input bit v, input int re, input int im, input bit sof);
      sin_valid = v;
      sin_real  = W'(re);
      sin_imag  = W'(im);
      sin_sof   = sof;
      cycle();
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_re_a"}, re_a, '0);
      chk({tag, "_im_a"}, im_a, '0);
      chk({tag, "_re_b"}, re_b, '0);
      chk({tag, "_im_b"}, im_b, '0);
      chk({tag, "_dv"}, frame_t'({dv_a, dv_b}), '0);
      chk({tag, "_busy"}, frame_t'({busy_a, busy_b}), '0);
      chk({tag, "_err"}, frame_t'({err_a, err_b}), '0);
   endtask

   // Scoreboard side: every output transfer consumes one predicted frame.
   always @(negedge clk) begin
      if (!rst && dv_a && !dout_busy) begin
         if (qa_re.size() == 0) begin
            n_vec++; n_bad++;
            $error("FAIL frame_a: got unexpected frame %0h expected none", re_a);
         end else begin
            chk("frame_re_a", re_a, qa_re.pop_front());
            chk("frame_im_a", im_a, qa_im.pop_front());
         end
      end
      if (!rst && dv_b && !dout_busy) begin
         if (qb_re.size() == 0) begin
            n_vec++; n_bad++;
            $error("FAIL frame_b: got unexpected frame %0h expected none", re_b);
         end else begin
            chk("frame_re_b", re_b, qb_re.pop_front());
            chk("frame_im_b", im_b, qb_im.pop_front());
         end
      end
   end

   initial begin
      int k;
      frame_t exp_v;

      // reset state
      rst = 1'b1;
      cycle(); cycle();
      rst = 1'b0;
      cycle();
      chk_reset_vals("reset");

      // single frame, natural input order 0..7
      for (int i = 0; i < NN; i++) drive(1, i, 100 + i, i == 0);
      sin_valid = 1'b0;
      exp_v = 128'h0007_0003_0005_0001_0006_0002_0004_0000; chk("brev_re", re_a, exp_v);
      exp_v = 128'h006B_0067_0069_0065_006A_0066_0068_0064; chk("brev_im", im_a, exp_v);
      exp_v = 128'h0007_0006_0005_0004_0003_0002_0001_0000; chk("nat_re", re_b, exp_v);
      exp_v = 128'h006B_006A_0069_0068_0067_0066_0065_0064; chk("nat_im", im_b, exp_v);
      drive(0, 0, 0, 0); drive(0, 0, 0, 0);

      // two back-to-back frames
      for (int i = 0; i < 2*NN; i++) drive(1, 16 + i, 200 + i, 0);
      drive(0, 0, 0, 0); drive(0, 0, 0, 0);

      // backpressure: frame 1 parked, frame 2 fills, input stalls until a release
      k = 0;
      for (int c = 0; c < 40; c++) begin
         bit will_acc;
         dout_busy = (c != 22) && (c < 32);
         will_acc  = (k < 3*NN) && !m_full;
         if (k < 3*NN) drive(1, 400 + k, 600 + k, 0);
         else          drive(0, 0, 0, 0);
         if (will_acc) k++;
      end
      dout_busy = 1'b0;
      chk("bp_all_accepted", frame_t'(k), frame_t'(3*NN));
      drive(0, 0, 0, 0);

      // start-of-frame in mid-frame discards the partial data
      for (int i = 0; i < 3; i++) drive(1, 300 + i, 310 + i, 0);
      drive(1, 50, 55, 1);
      for (int i = 1; i < NN; i++) drive(1, 50 + i, 55 + i, 0);
      sin_valid = 1'b0;
      chk("sof_slot0_re_b", frame_t'(re_b[W-1:0]), frame_t'(50));
      chk("sof_slot0_re_a", frame_t'(re_a[W-1:0]), frame_t'(50));
      drive(0, 0, 0, 0); drive(0, 0, 0, 0);

      // reset in mid-frame
      for (int i = 0; i < 5; i++) drive(1, 700 + i, 800 + i, 0);
      sin_valid = 1'b0;
      rst = 1'b1;
      cycle();
      rst = 1'b0;
      chk_reset_vals("midrst");
      for (int i = 0; i < NN; i++) drive(1, 900 + i, 1000 + i, 0);
      drive(0, 0, 0, 0); drive(0, 0, 0, 0); drive(0, 0, 0, 0);

      chk("all_frames_seen_a", frame_t'(qa_re.size()), '0);
      chk("all_frames_seen_b", frame_t'(qb_re.size()), '0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
